// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Holds default channel width/count and the select-width helper; no state.
package stream_mux_pkg;

  localparam int unsigned DEF_N = 8;
  localparam int unsigned DEF_M = 4;

  function automatic int unsigned sel_w(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr_i, wrapping to 0.
// Ports: req_i (M), ptr_i (S), en_i -> grant_o (one-hot M, gated by en_i),
// index_o (S, winning channel; valid when any req_i bit is set).
module rr_arbiter #(
  parameter int unsigned M = 4,
  parameter int unsigned S = 2
) (
  input  logic [M-1:0] req_i,
  input  logic [S-1:0] ptr_i,
  input  logic         en_i,
  output logic [M-1:0] grant_o,
  output logic [S-1:0] index_o
);

  logic         found;
  logic [S-1:0] idx;
  logic [S-1:0] cand;
  int           c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    c     = 0;
    for (int k = 0; k < int'(M); k++) begin
      c    = (int'(ptr_i) + k) % int'(M);
      cand = S'(c);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (en_i && found) begin
      grant_o[idx] = 1'b1;
    end
  end

  assign index_o = idx;

endmodule

// File: rtl/stream_mux_rr.sv
// M-to-1 valid/ready stream mux, round-robin arbitration, registered output.
// Ports: clk, reset (sync, active-high), in_valid/in_data/in_ready per
// channel, out_valid/out_data/out_sel/out_ready downstream.
// Optional: define STREAM_MUX_LOCK_EN to add in_last and packet locking.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N = DEF_N,
  parameter  int unsigned M = DEF_M,
  localparam int unsigned S = sel_w(M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M-1:0]   in_valid,
  input  logic [M*N-1:0] in_data,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [M-1:0]   in_last,
`endif
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [S-1:0]   out_sel,
  input  logic           out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [S-1:0] out_sel_q, out_sel_d;
  logic [S-1:0] ptr_q, ptr_d;

  logic         load_en;
  logic [M-1:0] arb_req;
  logic [S-1:0] arb_ptr;
  logic [M-1:0] grant;
  logic [S-1:0] g_idx;
  logic         xfer;
  logic [S-1:0] g_nxt;

  // Register empty or draining this cycle; reset blocks all accepts.
  assign load_en = !out_valid_q || out_ready;

`ifdef STREAM_MUX_LOCK_EN
  logic         lock_q, lock_d;
  logic [S-1:0] lock_ch_q, lock_ch_d;

  // While locked only the owning channel may request, searched from itself.
  assign arb_req = lock_q ? (in_valid & (M'(1) << lock_ch_q)) : in_valid;
  assign arb_ptr = lock_q ? lock_ch_q : ptr_q;
`else
  assign arb_req = in_valid;
  assign arb_ptr = ptr_q;
`endif

  rr_arbiter #(
    .M (M),
    .S (S)
  ) u_arb (
    .req_i   (arb_req),
    .ptr_i   (arb_ptr),
    .en_i    (load_en && !reset),
    .grant_o (grant),
    .index_o (g_idx)
  );

  assign in_ready = grant;
  assign xfer     = |grant;
  assign g_nxt    = (int'(g_idx) == int'(M) - 1) ? '0 : g_idx + S'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(g_idx)*N +: N];
      out_sel_d   = g_idx;
`ifdef STREAM_MUX_LOCK_EN
      if (in_last[g_idx]) begin
        lock_d = 1'b0;
        ptr_d  = g_nxt;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = g_idx;
      end
`else
      ptr_d = g_nxt;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (M=4, N=8): vector table, scoreboard
// for beat data, and hand sequences for hold, data path and packet locking.
module tb_stream_mux_rr;

  localparam int N = 8;
  localparam int M = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [M-1:0]   in_valid;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_last;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_ready;

  stream_mux_rr #(
    .N (N),
    .M (M)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] erdy;
    logic       eov;
    logic [1:0] esel;
    logic [7:0] edata;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] iv,
                              input logic o, input logic [3:0] er,
                              input logic ev, input logic [1:0] es,
                              input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.iv = iv; v.ordy = o; v.erdy = er;
    v.eov = ev; v.esel = es; v.edata = ed;
    return v;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < M; i++) in_data[i*N +: N] = 8'hA0 + 8'(i);
  endtask

  task automatic drive(input logic r, input logic [3:0] iv,
                       input logic o);
    @(negedge clk);
    reset     = r;
    in_valid  = iv;
    out_ready = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called before the edge: pops the beat leaving on this edge, if any.
  task automatic sb_pop(input string name);
    beat_t b;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk({name, "_underflow"}, 32'(sb.size()), 32'd1);
      end else begin
        b = sb.pop_front();
        chk({name, "_sel"}, 32'(out_sel), 32'(b.sel));
        chk({name, "_data"}, 32'(out_data), 32'(b.data));
      end
    end
  endtask

  task automatic sb_push(input logic [1:0] ch, input logic [7:0] d);
    beat_t b;
    b.sel = ch; b.data = d;
    sb.push_back(b);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_last = '1;
    set_data();

    // rst, in_valid, out_ready, exp in_ready, exp out_valid/sel/data after edge
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, 1, 4'h1, 1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 1, 4'h2, 1, 1, 8'hA1));
    tbl.push_back(mk(0, 4'hF, 1, 4'h4, 1, 2, 8'hA2));
    tbl.push_back(mk(0, 4'hF, 1, 4'h8, 1, 3, 8'hA3));
    tbl.push_back(mk(0, 4'hF, 1, 4'h1, 1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 1, 4'h2, 1, 1, 8'hA1));
    tbl.push_back(mk(0, 4'h2, 1, 4'h2, 1, 1, 8'hA1));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 0, 1, 8'hA1));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 1, 8'hA1));
    tbl.push_back(mk(0, 4'hF, 0, 4'h4, 1, 2, 8'hA2));
    tbl.push_back(mk(0, 4'hF, 0, 4'h0, 1, 2, 8'hA2));
    tbl.push_back(mk(1, 4'hF, 0, 4'h0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, 1, 4'h1, 1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h8, 1, 4'h8, 1, 3, 8'hA3));
    tbl.push_back(mk(0, 4'hA, 1, 4'h2, 1, 1, 8'hA1));
    tbl.push_back(mk(0, 4'hA, 1, 4'h8, 1, 3, 8'hA3));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 0, 3, 8'hA3));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].ordy);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
      if (tbl[i].rst) begin
        sb.delete();
      end else begin
        sb_pop($sformatf("v%0d_sb", i));
        if (tbl[i].erdy != 0)
          sb_push(oh2idx(tbl[i].erdy), 8'hA0 + 8'(oh2idx(tbl[i].erdy)));
      end
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].esel));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].edata));
    end
    chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // Held beat must ignore changing input data; then new data flows through.
    drive(1, 4'h0, 0);
    sb.delete();
    tick();
    drive(0, 4'h1, 0);
    chk("h_load_rdy", 32'(in_ready), 32'h1);
    sb_push(2'd0, 8'hA0);
    tick();
    in_data[0 +: N] = 8'h55;
    for (int k = 0; k < 2; k++) begin
      drive(0, 4'h1, 0);
      chk($sformatf("h_hold%0d_rdy", k), 32'(in_ready), 32'h0);
      tick();
      chk($sformatf("h_hold%0d_data", k), 32'(out_data), 32'hA0);
      chk($sformatf("h_hold%0d_valid", k), 32'(out_valid), 32'h1);
    end
    drive(0, 4'h0, 1);
    sb_pop("h_drain");
    begin
      int budget;
      budget = 4;
      tick();
      while (out_valid && budget > 0) begin
        tick();
        budget--;
      end
      chk("h_drain_lat", 32'(budget), 32'd4);
    end
    drive(0, 4'h1, 1);
    chk("h_new_rdy", 32'(in_ready), 32'h1);
    sb_push(2'd0, 8'h55);
    tick();
    drive(0, 4'h0, 1);
    sb_pop("h_new");
    tick();
    set_data();
    chk("h_sb_empty", 32'(sb.size()), 32'd0);

`ifdef STREAM_MUX_LOCK_EN
    begin
      logic [3:0] lasts [4];
      logic [1:0] exps  [4];
      lasts[0] = 4'h0; lasts[1] = 4'h0; lasts[2] = 4'h4; lasts[3] = 4'hF;
      exps[0] = 2'd2; exps[1] = 2'd2; exps[2] = 2'd2; exps[3] = 2'd3;
      drive(1, 4'h0, 1);
      sb.delete();
      tick();
      in_last = 4'hF;
      drive(0, 4'h2, 1);
      chk("lk_pre_rdy", 32'(in_ready), 32'h2);
      sb_push(2'd1, 8'hA1);
      tick();
      for (int k = 0; k < 4; k++) begin
        drive(0, 4'hF, 1);
        in_last = lasts[k];
        #1;
        chk($sformatf("lk%0d_rdy", k), 32'(in_ready),
            32'(4'h1 << exps[k]));
        sb_pop($sformatf("lk%0d_sb", k));
        sb_push(exps[k], 8'hA0 + 8'(exps[k]));
        tick();
        chk($sformatf("lk%0d_sel", k), 32'(out_sel), 32'(exps[k]));
      end
      drive(0, 4'h0, 1);
      sb_pop("lk_drain");
      tick();
      in_last = '1;
      chk("lk_sb_empty", 32'(sb.size()), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
